// File: rtl/sample_filter_mac.sv
// Time-multiplexed single-multiplier filter for the ADC->DAC sample path: mute, bypass, N-tap FIR, first-order IIR.
// Optional feature macro: FILTER_IIR_EN (mode 11 is the IIR when defined, otherwise it behaves as mute).
module sample_filter_mac #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 8,
    parameter int ACC_W  = 40
) (
    input  logic                      clk_i,
    input  logic                      reset_ni,
    input  logic                      start_i,
    input  logic signed [DATA_W-1:0]  data_i,
    input  logic [1:0]                mode_i,
    input  logic                      coef_we_i,
    input  logic [$clog2(TAPS)-1:0]   coef_addr_i,
    input  logic signed [COEF_W-1:0]  coef_data_i,
    output logic signed [DATA_W-1:0]  data_o,
    output logic                      valid_o,
    output logic                      busy_o,
    output logic                      overrun_o
);

    // state   | meaning
    // IDLE    | waiting for start_i; mute/bypass complete here in one edge
    // MAC     | one coefficient*operand product accumulated per cycle
    // OUT     | round, saturate, publish data_o with a valid_o pulse
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MAC  = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    localparam logic [1:0] MODE_MUTE = 2'b00;
    localparam logic [1:0] MODE_BYP  = 2'b01;
    localparam logic [1:0] MODE_FIR  = 2'b10;
    localparam logic [1:0] MODE_IIR  = 2'b11;

    localparam int AW = $clog2(TAPS);
    localparam int PW = DATA_W + COEF_W;

    localparam logic [ACC_W-1:0]         RND      = ACC_W'(1) << (COEF_W - 2);
    localparam logic signed [COEF_W-1:0] COEF_ONE = {1'b0, {(COEF_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] OUT_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] OUT_MIN  = {1'b1, {(DATA_W-1){1'b0}}};

    logic [1:0]               state_q, state_d;
    logic [1:0]               mode_q, mode_d;
    logic [AW-1:0]            k_q, k_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [DATA_W-1:0] x_q [TAPS];
    logic signed [DATA_W-1:0] x_d [TAPS];
    logic signed [COEF_W-1:0] coef_q [TAPS];
    logic signed [COEF_W-1:0] coef_d [TAPS];
    logic signed [DATA_W-1:0] data_q, data_d;
    logic                     valid_q, valid_d;
    logic                     overrun_q, overrun_d;
`ifdef FILTER_IIR_EN
    logic signed [DATA_W-1:0] y_prev_q, y_prev_d;
`endif

    logic                     is_iir;
    logic                     last_tap;
    logic signed [DATA_W-1:0] operand;
    logic signed [PW-1:0]     prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  rnd_sum;
    logic signed [ACC_W-1:0]  shifted;
    logic                     ovf;
    logic signed [DATA_W-1:0] sat_val;

    assign is_iir   = (mode_q == MODE_IIR);
    assign last_tap = is_iir ? (k_q == AW'(2)) : (k_q == AW'(TAPS - 1));

    // IIR reuses the FIR datapath: taps 0/1 read the delay line, tap 2 reads the fed-back output
    always_comb begin
        operand = x_q[k_q];
`ifdef FILTER_IIR_EN
        if (is_iir && (k_q == AW'(2))) begin
            operand = y_prev_q;
        end
`endif
    end

    assign prod     = coef_q[k_q] * operand;
    assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};
    assign rnd_sum  = acc_q + RND;
    assign shifted  = rnd_sum >>> (COEF_W - 1);

    // The result fits only if every bit from the DATA_W sign position upward agrees
    assign ovf      = (|shifted[ACC_W-1:DATA_W-1]) && !(&shifted[ACC_W-1:DATA_W-1]);
    assign sat_val  = ovf ? (shifted[ACC_W-1] ? OUT_MIN : OUT_MAX) : shifted[DATA_W-1:0];

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        k_d       = k_q;
        acc_d     = acc_q;
        x_d       = x_q;
        coef_d    = coef_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        overrun_d = overrun_q;

        if (coef_we_i && (state_q == ST_IDLE) && (int'(coef_addr_i) < TAPS)) begin
            coef_d[coef_addr_i] = coef_data_i;
        end

        if (start_i && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    for (int i = TAPS - 1; i > 0; i--) begin
                        x_d[i] = x_q[i-1];
                    end
                    x_d[0] = data_i;
                    mode_d = mode_i;
                    case (mode_i)
                        MODE_BYP: begin
                            data_d  = data_i;
                            valid_d = 1'b1;
                        end
                        MODE_FIR: begin
                            acc_d   = '0;
                            k_d     = '0;
                            state_d = ST_MAC;
                        end
`ifdef FILTER_IIR_EN
                        MODE_IIR: begin
                            acc_d   = '0;
                            k_d     = '0;
                            state_d = ST_MAC;
                        end
`endif
                        default: begin
                            data_d  = '0;
                            valid_d = 1'b1;
                        end
                    endcase
                end
            end
            ST_MAC: begin
                acc_d = acc_q + prod_ext;
                k_d   = k_q + AW'(1);
                if (last_tap) begin
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                data_d  = sat_val;
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef FILTER_IIR_EN
    assign y_prev_d = valid_d ? data_d : y_prev_q;
`endif

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_MUTE;
            k_q       <= '0;
            acc_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                x_q[i]    <= '0;
                coef_q[i] <= (i == 0) ? COEF_ONE : '0;
            end
`ifdef FILTER_IIR_EN
            y_prev_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            k_q       <= k_d;
            acc_q     <= acc_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            x_q       <= x_d;
            coef_q    <= coef_d;
`ifdef FILTER_IIR_EN
            y_prev_q  <= y_prev_d;
`endif
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign busy_o    = (state_q != ST_IDLE);
    assign overrun_o = overrun_q;

endmodule
